vm2002_txn_ctrl: RTL
====================

Name: vm2002_txn_ctrl

Overview:
Transaction sequencer for the vm2002 vending machine. Holds the 8-entry inventory/price table written by the supplier interface and accumulates user coins into a balance. On select it checks stock and price, dispenses the item, and then pays back change one coin per cycle. It is the control core behind the vm2002 product/status/balance/info outputs.

Parameters:
MAX_BALANCE, 16'd1000, saturation ceiling for balance (cents); a coin that would exceed it is rejected
TIMEOUT_CYCLES, 255, idle cycles in COLLECT before auto-refund (only with VM2002_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
coins  in  2  coin inserted this cycle: 00 none, 01 nickel=5, 10 dime=10, 11 quarter=25
buttons  in  3  item index selected by the user
select  in  1  one-cycle purchase request for buttons
cancel  in  1  one-cycle refund request
item  in  3  supplier table index
count  in  4  supplier stock count
cost  in  8  supplier price in cents; must be a multiple of 5
valid  in  1  supplier write strobe
product  out  3  index of the last dispensed item
vend  out  1  one-cycle dispense pulse
status  out  2  00 none, 01 vended, 10 insufficient funds, 11 sold out
balance  out  16  current credit in cents
info  out  8  cost on insufficient funds; remaining count after vend; 0 on sold out
change  out  2  coin returned this cycle, same encoding as coins
coin_en  out  1  combinational; 1 in IDLE/COLLECT (coins accepted)
supply_ready  out  1  combinational; 1 in IDLE/COLLECT (supplier writes accepted)

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset state: state=IDLE; every table entry count=0, cost=0.
- Reset output values: product, vend, status, balance, info and change all 0.
- States: IDLE, COLLECT, CHECK, VEND, CHANGE.
- Supplier write:
  - Condition: valid && supply_ready.
  - Action: table[item] gets {count, cost} at the edge.
  - valid while not ready is dropped; there is no queueing.
  - A write and a coin in the same cycle are both honoured.
- Coins (IDLE/COLLECT, coins!=0):
  - balance += value at the next edge.
  - IDLE moves to COLLECT.
  - If balance+value > MAX_BALANCE: balance is unchanged and change=coins for one cycle (coin returned).
- Coins outside IDLE/COLLECT are ignored.
- COLLECT priority: cancel > select > coin.
  - cancel goes to CHANGE.
  - select latches buttons into sel and goes to CHECK; a coin in the same cycle is ignored.
- select in IDLE with balance 0: go to CHECK with the same rules as COLLECT.
- CHECK (1 cycle), reads table[sel]:
  - count==0: status=11, info=0, go to COLLECT.
  - balance<cost: status=10, info=cost, go to COLLECT.
  - otherwise: go to VEND.
  - A supplier write to sel in the cycle before CHECK is visible in CHECK.
- VEND (1 cycle):
  - vend=1, product=sel, status=01.
  - table[sel].count -= 1; info = the new count.
  - balance -= cost.
  - Go to CHANGE.
- CHANGE, one coin per cycle, greedy:
  - balance>=25: change=11, balance -= 25.
  - else balance>=10: change=10, balance -= 10.
  - else balance>=5: change=01, balance -= 5.
  - else: balance=0, change=00, go to IDLE. A sub-5 remainder is forfeited.
- Entering IDLE clears status to 00. product and info hold their values.
- vend and change are 0 in every cycle not listed above.
- rst mid-transaction: immediate return to reset state; credit is lost by design.
- All arithmetic is unsigned. balance is never negative (guaranteed by CHECK).

Optional Feature:
- Macro: VM2002_TIMEOUT_EN.
- Defined: an 8-bit idle counter runs in COLLECT.
  - It resets on any coin, select or cancel.
  - At TIMEOUT_CYCLES it forces CHANGE (auto-refund).
  - Counter reset value is 0.
- Undefined: no counter; COLLECT waits indefinitely.

Test Plan:
- Restock item 2 (count=3, cost=35); insert quarter then dime; select item 2 -> CHECK, then VEND: vend=1, product=2, status=01, info=2, balance=0; no change coins; back to IDLE.
- Item 5 (cost=20); insert quarter+quarter; select 5 -> vend; change sequence 11 then 01 (30 cents); balance 0; IDLE.
- Item 4 with count=0; balance 50; select 4 -> status=11, info=0, balance stays 50, state COLLECT.
- Item 1 (cost=60); balance 25; select 1 -> status=10, info=60; then cancel -> change=11; balance 0.
- MAX_BALANCE=30; insert quarter then dime -> dime rejected: change=10 for one cycle, balance stays 25.
- Restock item 3 in the same cycle as select of item 3 while in COLLECT -> CHECK uses the new count/cost. With VM2002_TIMEOUT_EN and TIMEOUT_CYCLES=4: balance 10, no activity -> refund change=10 after 4 cycles.

Source files
------------

// File: rtl/vm2002_txn_ctrl.sv
// vm2002 transaction sequencer: supplier price/stock table, coin credit, vend and greedy change.
// Optional idle auto-refund in COLLECT is enabled by defining VM2002_TIMEOUT_EN.
module vm2002_txn_ctrl #(
    parameter logic [15:0] MAX_BALANCE    = 16'd1000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  coins,
    input  logic [2:0]  buttons,
    input  logic        select,
    input  logic        cancel,
    input  logic [2:0]  item,
    input  logic [3:0]  count,
    input  logic [7:0]  cost,
    input  logic        valid,
    output logic [2:0]  product,
    output logic        vend,
    output logic [1:0]  status,
    output logic [15:0] balance,
    output logic [7:0]  info,
    output logic [1:0]  change,
    output logic        coin_en,
    output logic        supply_ready
);

    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, VEND, CHANGE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q  [8];
    logic [7:0]  cost_q [8];
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  product_q, product_d;
    logic        vend_q, vend_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] balance_q, balance_d;
    logic [7:0]  info_q, info_d;
    logic [1:0]  change_q, change_d;

    logic        accepting;
    logic        cancel_hit;
    logic [15:0] coin_val;
    logic [16:0] coin_sum;
    logic        coin_ok;
    logic [3:0]  sel_cnt;
    logic [7:0]  sel_cost;
    logic        timeout;

    assign accepting    = (state_q == IDLE) || (state_q == COLLECT);
    assign coin_en      = accepting;
    assign supply_ready = accepting;
    assign cancel_hit   = (state_q == COLLECT) && cancel;
    assign sel_cnt      = cnt_q[sel_q];
    assign sel_cost     = cost_q[sel_q];

    always_comb begin
        coin_val = '0;
        case (coins)
            2'b01:   coin_val = 16'd5;
            2'b10:   coin_val = 16'd10;
            2'b11:   coin_val = 16'd25;
            default: coin_val = '0;
        endcase
    end

    assign coin_sum = {1'b0, balance_q} + {1'b0, coin_val};
    assign coin_ok  = coin_sum <= {1'b0, MAX_BALANCE};

`ifdef VM2002_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] idle_q;
    logic       activity;

    assign activity = (coins != 2'b00) || select || cancel;
    assign timeout  = (state_q == COLLECT) && !activity && (idle_q == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst || state_q != COLLECT || activity) idle_q <= '0;
        else                                       idle_q <= idle_q + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (select)              state_d = CHECK;
                else if (coins != 2'b00) state_d = COLLECT;
            end
            COLLECT: begin
                if (cancel || timeout) state_d = CHANGE;
                else if (select)       state_d = CHECK;
            end
            CHECK: begin
                if (sel_cnt == 4'd0 || balance_q < {8'd0, sel_cost}) state_d = COLLECT;
                else                                                 state_d = VEND;
            end
            VEND:    state_d = CHANGE;
            CHANGE:  if (balance_q < 16'd5) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d     = sel_q;
        product_d = product_q;
        status_d  = status_q;
        balance_d = balance_q;
        info_d    = info_q;
        vend_d    = 1'b0;
        change_d  = 2'b00;
        case (state_q)
            IDLE, COLLECT: begin
                // cancel outranks select, which outranks a coin in the same cycle
                if (!cancel_hit) begin
                    if (select) begin
                        sel_d = buttons;
                    end else if (coins != 2'b00) begin
                        if (coin_ok) balance_d = coin_sum[15:0];
                        else         change_d  = coins;
                    end
                end
            end
            CHECK: begin
                if (sel_cnt == 4'd0) begin
                    status_d = 2'b11;
                    info_d   = '0;
                end else if (balance_q < {8'd0, sel_cost}) begin
                    status_d = 2'b10;
                    info_d   = sel_cost;
                end
            end
            VEND: begin
                vend_d    = 1'b1;
                product_d = sel_q;
                status_d  = 2'b01;
                info_d    = {4'd0, sel_cnt - 4'd1};
                balance_d = balance_q - {8'd0, sel_cost};
            end
            CHANGE: begin
                if (balance_q >= 16'd25) begin
                    change_d  = 2'b11;
                    balance_d = balance_q - 16'd25;
                end else if (balance_q >= 16'd10) begin
                    change_d  = 2'b10;
                    balance_d = balance_q - 16'd10;
                end else if (balance_q >= 16'd5) begin
                    change_d  = 2'b01;
                    balance_d = balance_q - 16'd5;
                end else begin
                    balance_d = '0;
                    status_d  = 2'b00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            product_q <= '0;
            vend_q    <= 1'b0;
            status_q  <= '0;
            balance_q <= '0;
            info_q    <= '0;
            change_q  <= '0;
        end else begin
            sel_q     <= sel_d;
            product_q <= product_d;
            vend_q    <= vend_d;
            status_q  <= status_d;
            balance_q <= balance_d;
            info_q    <= info_d;
            change_q  <= change_d;
        end
    end

    // Supplier writes only land in IDLE/COLLECT, so they never collide with the VEND decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                cnt_q[i]  <= '0;
                cost_q[i] <= '0;
            end
        end else if (valid && supply_ready) begin
            cnt_q[item]  <= count;
            cost_q[item] <= cost;
        end else if (state_q == VEND) begin
            cnt_q[sel_q] <= sel_cnt - 4'd1;
        end
    end

    assign product = product_q;
    assign vend    = vend_q;
    assign status  = status_q;
    assign balance = balance_q;
    assign info    = info_q;
    assign change  = change_q;

endmodule
